// File: rtl/priority_7seg_pkg.sv
// priority_7seg_pkg: shared FSM state type and seven-segment constants for priority_scan_7seg.
package priority_7seg_pkg;
  typedef enum logic [1:0] {EMPTY, PRIO, SCAN} state_t;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  // segments a..g on bits 0..6, indexed by hex digit
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: combinational hex digit to active-high a..g segment decode.
module hex_to_7seg
  import priority_7seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_TABLE[hex_i];
endmodule

// File: rtl/priority_scan_7seg.sv
// priority_scan_7seg: shows the highest active request, or scans all active requests, on a 7-segment digit.
module priority_scan_7seg
  import priority_7seg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DWELL = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  input  logic             mode,
  input  logic             hold,
  output logic [6:0]       digit,
  output logic             no_data,
  output logic [3:0]       index
);
  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
  state_t state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0] digit_q, seg;
  logic nd_q;
  logic [3:0] hi, below;
  logic found;
  // highest set bit, and highest set bit strictly below the shown index
  always_comb begin
    hi = '0;
    below = '0;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) hi = 4'(i);
      if (data[i] && 4'(i) < idx_q) begin
        below = 4'(i);
        found = 1'b1;
      end
    end
  end
  // hold only freezes a live display; an empty display always re-evaluates
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (data == '0) begin
      state_d = EMPTY;
      idx_d = '0;
      cnt_d = '0;
    end else if (!(hold && state_q != EMPTY)) begin
      if (!mode) begin
        state_d = PRIO;
        idx_d = hi;
        cnt_d = '0;
      end else if (state_q != SCAN) begin
        state_d = SCAN;
        idx_d = hi;
        cnt_d = '0;
      end else if (cnt_q == LAST) begin
        cnt_d = '0;
        idx_d = found ? below : hi;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end
  hex_to_7seg u_hex (
    .hex_i(idx_d),
    .seg_o(seg)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      idx_q <= '0;
      cnt_q <= '0;
      digit_q <= SEG_BLANK;
      nd_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      digit_q <= (state_d == EMPTY) ? SEG_BLANK : seg;
      nd_q <= (state_d == EMPTY);
    end
  end
  assign digit = digit_q;
  assign no_data = nd_q;
  assign index = idx_q;
endmodule

// File: tb/tb_priority_scan_7seg.sv
// tb_priority_scan_7seg: directed vector table plus hand-written scan/hold/reset sequences, WIDTH=8, DWELL=3.
module tb_priority_scan_7seg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] data = '0;
  logic mode = 1'b0;
  logic hold = 1'b0;
  logic [6:0] digit;
  logic no_data;
  logic [3:0] index;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [7:0] d;
    logic       m;
    logic [3:0] idx;
    logic       nd;
  } vec_t;
  vec_t vt [9];
  priority_scan_7seg #(.WIDTH(8), .DWELL(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data(data),
    .mode(mode),
    .hold(hold),
    .digit(digit),
    .no_data(no_data),
    .index(index)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] ref_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [3:0] ei, input logic en);
    logic [6:0] es;
    es = en ? 7'h00 : ref_seg(ei);
    checks++;
    if (index !== ei || digit !== es || no_data !== en) begin
      errors++;
      $display("FAIL %s: got index=%0d digit=%h no_data=%b, want index=%0d digit=%h no_data=%b",
               name, index, digit, no_data, ei, es, en);
    end
  endtask
  initial begin
    logic [3:0] seq [12];
    logic [3:0] h;
    vt[0] = '{8'h24, 1'b0, 4'd5, 1'b0};
    vt[1] = '{8'h01, 1'b0, 4'd0, 1'b0};
    vt[2] = '{8'h80, 1'b0, 4'd7, 1'b0};
    vt[3] = '{8'h00, 1'b0, 4'd0, 1'b1};
    vt[4] = '{8'h0F, 1'b0, 4'd3, 1'b0};
    vt[5] = '{8'hFF, 1'b0, 4'd7, 1'b0};
    vt[6] = '{8'h40, 1'b1, 4'd6, 1'b0};
    vt[7] = '{8'h40, 1'b1, 4'd6, 1'b0};
    vt[8] = '{8'h00, 1'b1, 4'd0, 1'b1};
    seq = '{4'd7, 4'd7, 4'd7, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd7, 4'd7, 4'd7};
    // reset with busy inputs
    data = 8'hFF;
    mode = 1'b1;
    hold = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    chk("reset", 4'd0, 1'b1);
    data = '0;
    mode = 1'b0;
    hold = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_reset_empty", 4'd0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      data = vt[i].d;
      mode = vt[i].m;
      tick();
      chk($sformatf("vec%0d", i), vt[i].idx, vt[i].nd);
    end
    // scan sequence 7,1,0,7 with 3-cycle dwell
    mode = 1'b1;
    data = 8'b1000_0011;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("scan_seq%0d", i), seq[i], 1'b0);
    end
    tick();
    tick();
    chk("scan_on_1", 4'd1, 1'b0);
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("hold%0d", i), 4'd1, 1'b0);
    end
    hold = 1'b0;
    tick();
    chk("hold_release_remaining", 4'd1, 1'b0);
    tick();
    chk("hold_release_advance", 4'd0, 1'b0);
    tick();
    data = '0;
    tick();
    chk("scan_data_zero", 4'd0, 1'b1);
    data = 8'h10;
    tick();
    chk("scan_reenter", 4'd4, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("single_bit%0d", i), 4'd4, 1'b0);
    end
    // stale index kept until dwell expiry, then advance on current data
    data = '0;
    tick();
    data = 8'h83;
    tick();
    chk("stale_enter", 4'd7, 1'b0);
    data = 8'h03;
    tick();
    chk("stale_keep0", 4'd7, 1'b0);
    tick();
    chk("stale_keep1", 4'd7, 1'b0);
    tick();
    chk("stale_advance", 4'd1, 1'b0);
    data = 8'h83;
    tick();
    mode = 1'b0;
    tick();
    chk("scan_to_prio", 4'd7, 1'b0);
    // reset mid-scan while held
    mode = 1'b1;
    tick();
    tick();
    hold = 1'b1;
    rst_n = 1'b0;
    tick();
    chk("reset_mid_scan", 4'd0, 1'b1);
    rst_n = 1'b1;
    hold = 1'b0;
    tick();
    chk("rescan0", 4'd7, 1'b0);
    tick();
    chk("rescan1", 4'd7, 1'b0);
    tick();
    chk("rescan2", 4'd7, 1'b0);
    tick();
    chk("rescan_advance", 4'd1, 1'b0);
    // exhaustive priority sweep
    mode = 1'b0;
    for (int d = 0; d < 256; d++) begin
      data = 8'(d);
      h = '0;
      for (int b = 0; b < 8; b++) if (data[b]) h = 4'(b);
      tick();
      chk($sformatf("sweep%0d", d), h, d == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/priority_scan_7seg.md
PRIORITY_SCAN_7SEG -- requirements
Module: priority_scan_7seg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of request inputs (legal 2..16).
REQ-002 SHALL have parameter DWELL, default 1000000, meaning clk cycles each index is shown in scan mode (legal >=1).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset: synchronous, active-low.
REQ-005 SHALL have port data  input  WIDTH  meaning request bits; bit i set = request i active.
REQ-006 SHALL have port mode  input  1  meaning 0 = priority (highest set bit), 1 = scan (cycle through all set bits).
REQ-007 SHALL have port hold  input  1  meaning 1 freezes the displayed index and dwell counter.
REQ-008 SHALL have port digit  output  7  meaning segments a..g on bits 0..6, active-high, hex of the displayed index.
REQ-009 SHALL have port no_data  output  1  meaning 1 when no request is active.
REQ-010 SHALL have port index  output  4  meaning the binary displayed index; bits above clog2(WIDTH) are 0.

Function
REQ-011 All outputs SHALL be registered; digit is hex-decoded from the registered index.
REQ-012 The FSM SHALL have states EMPTY, PRIO and SCAN.
REQ-013 Transitions SHALL be: data==0 -> EMPTY from any state; data!=0 with mode=0 -> PRIO; data!=0 with mode=1 -> SCAN. All are evaluated every cycle unless REQ-019 applies.
REQ-014 In EMPTY, the block SHALL drive no_data=1, index=0 and digit=7'h00 (blank), and SHALL clear the dwell counter.
REQ-015 In PRIO, index SHALL equal the highest set bit of data sampled on the previous edge (latency 1 cycle); dwell counter held at 0.
REQ-016 On entering SCAN from EMPTY or PRIO, index SHALL load the highest set bit and the dwell counter SHALL load 0.
REQ-017 In SCAN, the dwell counter SHALL increment each cycle. At count DWELL-1 it SHALL wrap to 0 and index SHALL advance to the next set bit strictly below the current index.
REQ-018 If no set bit lies below the current index, index SHALL wrap to the highest set bit. With a single set bit, index SHALL stay on it.
REQ-019 hold=1 SHALL freeze index, the dwell counter and the state, except that data==0 still forces EMPTY. On release, counting resumes from the frozen count.
REQ-020 In SCAN, if the displayed bit clears, the display SHALL keep the stale index until dwell expiry, then advance per REQ-017/018 using current data.
REQ-021 A mode change mid-dwell SHALL take effect on the next edge (SCAN->PRIO shows the highest bit; PRIO->SCAN per REQ-016).
REQ-022 The dwell counter SHALL be clog2(DWELL+1) bits wide and SHALL never exceed DWELL-1. DWELL=1 SHALL advance every cycle.
REQ-023 Hex decoding SHALL be standard: 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D, 7=7'h07, 8=7'h7F, 9=7'h6F, A=7'h77, b=7'h7C, C=7'h39, d=7'h5E, E=7'h79, F=7'h71.

Reset
REQ-024 While rst_n=0 at a clk edge, the block SHALL enter EMPTY with index=0, digit=7'h00, no_data=1 and dwell counter 0.
REQ-025 Reset SHALL override hold, mode and data, including mid-dwell.
REQ-026 The first post-reset edge with rst_n=1 SHALL evaluate REQ-013 normally.

Structure
REQ-027 Shared package priority_7seg_pkg SHALL hold the state enum (EMPTY/PRIO/SCAN), the 16-entry segment constant table and SEG_BLANK.
REQ-028 Hex-to-segment decoding SHALL be a sub-module hex_to_7seg (4-bit in, 7-bit out, combinational) instantiated once.
REQ-029 Highest-bit and next-lower-bit search SHALL be parametrised combinational logic inside priority_scan_7seg.

Verification (WIDTH=8, DWELL=3)
REQ-030 Reset, then mode=0, data=8'b0010_0100 -> next cycle index=5, digit=7'h6D, no_data=0.
REQ-031 mode=1, data=8'b1000_0011 -> index sequence 7,1,0,7 with each value held exactly 3 cycles.
REQ-032 SCAN showing 1, hold=1 for 10 cycles -> index stays 1; hold=0 -> remaining dwell then index=0.
REQ-033 SCAN mid-dwell, data->0 -> next cycle no_data=1, digit=7'h00, index=0; data->8'h10 -> index=4.
REQ-034 rst_n=0 for one cycle mid-SCAN with hold=1 -> outputs at reset values; dwell restarts at 0 on the return to SCAN.
REQ-035 Exhaustive PRIO sweep of all 256 data values -> index equals the reference highest-bit model and digit matches the REQ-023 table.
